// File: rtl/recip_div_req_if.sv
// Request/response and engine-side signals of the reciprocal-divide initiator.
// slave = the initiator block, master = its surroundings (requester, engine, consumer).
interface recip_div_req_if #(
  parameter int W = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_num;
  logic [W-1:0] in_den;
  logic         start_calc;
  logic [W-1:0] x_in;
  logic         done;
  logic [W-1:0] x_inv;
  logic         invalid;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_q;
  logic         err_div;
  logic         err_timeout;

  modport slave (
    input  in_valid, in_num, in_den, done, x_inv, invalid, out_ready,
    output in_ready, start_calc, x_in, out_valid, out_q, err_div, err_timeout
  );
  modport master (
    output in_valid, in_num, in_den, done, x_inv, invalid, out_ready,
    input  in_ready, start_calc, x_in, out_valid, out_q, err_div, err_timeout
  );
endinterface

// File: rtl/recip_div_req.sv
// Reciprocal-engine initiator: sends den, waits for 1/den under a watchdog,
// returns num*(1/den) in QF with saturation and error flags.
module recip_div_req #(
  parameter int W      = 32,
  parameter int F      = 16,
  parameter int TO_CYC = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  recip_div_req_if.slave  bus
);
  localparam int CW = $clog2(TO_CYC);
  localparam logic [CW-1:0] TERM = CW'(TO_CYC - 1);
  localparam logic signed [2*W:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, REQ, WAIT, MUL, OUT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  num_q, num_d;
  logic [W-1:0]  den_q, den_d;
  logic [W-1:0]  x_inv_q, x_inv_d;
  logic          inv_q, inv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          start_q, start_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_q_q, out_q_d;
  logic          err_div_q, err_div_d;
  logic          err_to_q, err_to_d;

  // Full-precision product; x_inv is unsigned so it gets a zero sign bit.
  logic signed [2*W:0] num_ext, xinv_ext, prod, shr;
  logic [W-1:0]        sat;

  always_comb begin
    num_ext  = {{(W+1){num_q[W-1]}}, num_q};
    xinv_ext = {{(W+1){1'b0}}, x_inv_q};
    prod     = num_ext * xinv_ext;
    shr      = prod >>> F;
    if (shr > MAXV)      sat = {1'b0, {(W-1){1'b1}}};
    else if (shr < MINV) sat = {1'b1, {(W-1){1'b0}}};
    else                 sat = shr[W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    den_d       = den_q;
    x_inv_d     = x_inv_q;
    inv_d       = inv_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    start_d     = 1'b0;
    out_valid_d = out_valid_q;
    out_q_d     = out_q_q;
    err_div_d   = err_div_q;
    err_to_d    = err_to_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid) begin
          num_d      = bus.in_num;
          den_d      = bus.in_den;
          start_d    = 1'b1;
          in_ready_d = 1'b0;
          state_d    = REQ;
        end
      end
      REQ: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done has priority over the watchdog's terminal count
        if (bus.done) begin
          x_inv_d = bus.x_inv;
          inv_d   = bus.invalid;
          state_d = MUL;
        end else if (cnt_q == TERM) begin
          out_q_d     = '0;
          err_to_d    = 1'b1;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MUL: begin
        out_q_d     = inv_q ? '0 : sat;
        err_div_d   = inv_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          err_div_d   = 1'b0;
          err_to_d    = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_q       <= '0;
      den_q       <= '0;
      x_inv_q     <= '0;
      inv_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      err_div_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      den_q       <= den_d;
      x_inv_q     <= x_inv_d;
      inv_q       <= inv_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      out_q_q     <= out_q_d;
      err_div_q   <= err_div_d;
      err_to_q    <= err_to_d;
    end
  end

  // den_q doubles as x_in: it is held from accept until the next request.
  assign bus.in_ready    = in_ready_q;
  assign bus.start_calc  = start_q;
  assign bus.x_in        = den_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_q       = out_q_q;
  assign bus.err_div     = err_div_q;
  assign bus.err_timeout = err_to_q;
endmodule

// File: tb/tb_recip_div_req.sv
// Bench for recip_div_req: directed requests against a behavioural reciprocal
// engine, expected responses queued and checked by an independent monitor.
module tb_recip_div_req;
  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;

  recip_div_req_if #(.W(32)) bus ();
  recip_div_req #(.W(32), .F(16), .TO_CYC(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] q;
    logic        ediv;
    logic        eto;
    int          lat;
    int          stall;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   eng_lat;
  bit   eng_never;
  int   stall_req;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Behavioural engine: done pulses eng_lat cycles after the start_calc cycle.
  initial begin
    logic [31:0] dd;
    bus.done = 1'b0; bus.x_inv = '0; bus.invalid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.start_calc && !eng_never) begin
        repeat (eng_lat) @(posedge clk);
        #1;
        dd = bus.x_in;
        bus.invalid = ($signed(dd) <= 0);
        bus.x_inv = bus.invalid ? 32'd0 : 32'((64'd1 << 32) / {32'd0, dd});
        bus.done = 1'b1;
        @(posedge clk);
        #1 bus.done = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    logic [31:0] sq;
    logic sd, st;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.out_ready = (stall_req == 0);
      if (rst_n && bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", {31'd0, bus.out_valid}, 32'd0);
          bus.out_ready = 1'b1;
        end else begin
          e = sb.pop_front();
          if (e.lat >= 0) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("out_q", bus.out_q, e.q);
          chk("err_div", {31'd0, bus.err_div}, {31'd0, e.ediv});
          chk("err_timeout", {31'd0, bus.err_timeout}, {31'd0, e.eto});
          if (e.stall > 0) begin
            sq = bus.out_q; sd = bus.err_div; st = bus.err_timeout;
            for (int i = 0; i < e.stall; i++) begin
              @(negedge clk);
              chk("stall_q", bus.out_q, sq);
              chk("stall_flags", {30'd0, bus.err_div, bus.err_timeout}, {30'd0, sd, st});
              chk("stall_valid_rdy", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
            end
            bus.out_ready = 1'b1;
          end
        end
        @(posedge clk);
      end
    end
  end

  task automatic send(input logic [31:0] n, input logic [31:0] d, input int elat,
                      input bit never, input exp_t e, input bit push);
    exp_t x;
    int   k;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) chk("in_ready_wait", 32'd0, 32'd1);
    eng_lat = elat; eng_never = never; stall_req = e.stall;
    bus.out_ready = (e.stall == 0);
    bus.in_num = n; bus.in_den = d; bus.in_valid = 1'b1;
    x = e;
    x.acc = cyc;
    if (push) sb.push_back(x);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && !bus.out_valid && bus.in_ready) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      chk("response_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_start"}, {31'd0, bus.start_calc}, 32'd0);
    chk({tag, "_x_in"}, bus.x_in, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_out_q"}, bus.out_q, 32'd0);
    chk({tag, "_errs"}, {30'd0, bus.err_div, bus.err_timeout}, 32'd0);
  endtask

  function automatic exp_t mk(input logic [31:0] q, input bit ed, input bit et,
                              input int lat, input int stall);
    exp_t e;
    e.q = q; e.ediv = ed; e.eto = et; e.lat = lat; e.stall = stall; e.acc = 0;
    return e;
  endfunction

  initial begin
    errors = 0; checks = 0; cyc = 0;
    eng_lat = 4; eng_never = 1'b0; stall_req = 0;
    bus.in_valid = 1'b0; bus.in_num = '0; bus.in_den = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // 3.0 / 2.0 = 1.5, engine done 9 cycles after accept
    send(32'd196608, 32'd131072, 8, 1'b0, mk(32'd98304, 0, 0, 11, 0), 1'b1);
    wait_idle();
    send(32'hFFFF0000, 32'd131072, 2, 1'b0, mk(32'hFFFF8000, 0, 0, 5, 0), 1'b1);
    wait_idle();
    send(32'h7FFF0000, 32'd16384, 3, 1'b0, mk(32'h7FFFFFFF, 0, 0, 6, 0), 1'b1);
    wait_idle();
    send(32'h80000000, 32'd16384, 3, 1'b0, mk(32'h80000000, 0, 0, 6, 0), 1'b1);
    wait_idle();
    // -1 LSB * 0.5 floors to -1 LSB
    send(32'hFFFFFFFF, 32'd131072, 1, 1'b0, mk(32'hFFFFFFFF, 0, 0, 4, 0), 1'b1);
    wait_idle();
    // 5.0 / 4.0 = 1.25 with consumer back-pressure
    send(32'd327680, 32'd262144, 4, 1'b0, mk(32'd81920, 0, 0, 7, 5), 1'b1);
    wait_idle();
    send(32'd65536, 32'd0, 3, 1'b0, mk(32'd0, 1, 0, 6, 0), 1'b1);
    wait_idle();
    send(32'd65536, 32'hFFFF0000, 3, 1'b0, mk(32'd0, 1, 0, 6, 0), 1'b1);
    wait_idle();
    // done on the watchdog's terminal cycle wins
    send(32'd196608, 32'd131072, 64, 1'b0, mk(32'd98304, 0, 0, 67, 0), 1'b1);
    wait_idle();
    send(32'd196608, 32'd131072, 0, 1'b1, mk(32'd0, 0, 1, 66, 0), 1'b1);
    wait_idle();
    // done arriving while presenting the timeout result is ignored
    send(32'd196608, 32'd131072, 65, 1'b0, mk(32'd0, 0, 1, 66, 0), 1'b1);
    wait_idle();
    // done arriving after returning to idle is ignored
    send(32'd196608, 32'd131072, 67, 1'b0, mk(32'd0, 0, 1, 66, 0), 1'b1);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stray_done_idle", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    end

    // reset while waiting on the engine
    send(32'd196608, 32'd131072, 0, 1'b1, mk(32'd0, 0, 0, -1, 0), 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    send(32'd196608, 32'd131072, 8, 1'b0, mk(32'd98304, 0, 0, 11, 0), 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
